// File: rtl/tri_fifo_skew_ctrl.sv
// tri_fifo_skew_ctrl: sequences SRAM row reads into the downward triangular skew FIFO and
// signals completion once the deepest active lane has emitted every vector of the tile.
module tri_fifo_skew_ctrl #(
  parameter int TRI_LENGTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_vec,
  input  logic [TRI_LENGTH-1:0] lane_mask,
  input  logic                  hold,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [TRI_LENGTH-1:0] fifo_enable_in,
  input  logic [TRI_LENGTH-1:0] fifo_enable_out,
  output logic                  busy,
  output logic                  done,
  output logic                  start_err
);
  localparam int LW = TRI_LENGTH > 1 ? $clog2(TRI_LENGTH) : 1;
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, rd_addr_q, rd_addr_d;
  logic [CNT_WIDTH-1:0] nv_q, nv_d, issued_q, issued_d, out_cnt_q, out_cnt_d;
  logic [TRI_LENGTH-1:0] mask_q, mask_d, fei_q, fei_d;
  logic [LW-1:0] act_q, act_d, low_idx;
  logic rd_en_q, rd_en_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic accept, issue;
  always_comb begin
    low_idx = '0;
    for (int i = TRI_LENGTH - 1; i >= 0; i--)
      if (lane_mask[i]) low_idx = LW'(i);
  end
  // The read for a cycle is decided at the preceding edge, so hold acts with one cycle of latency.
  always_comb begin
    accept    = state_q == IDLE && start && lane_mask != '0;
    issue     = !hold && ((accept && num_vec != '0) || (state_q == FEED && issued_q != nv_q));
    state_d   = state_q;
    base_d    = base_q;
    nv_d      = nv_q;
    mask_d    = mask_q;
    act_d     = act_q;
    issued_d  = issued_q;
    out_cnt_d = out_cnt_q;
    rd_addr_d = rd_addr_q;
    if (accept) begin
      base_d    = base_addr;
      nv_d      = num_vec;
      mask_d    = lane_mask;
      act_d     = low_idx;
      issued_d  = '0;
      out_cnt_d = '0;
      state_d   = num_vec == '0 ? DONE : FEED;
    end
    if (issue) begin
      rd_addr_d = (accept ? base_addr : base_q) + ADDR_WIDTH'(issued_d);
      issued_d  = issued_d + 1'b1;
    end
    if ((state_q == FEED || state_q == DRAIN) && fifo_enable_out[act_q] && out_cnt_q != nv_q)
      out_cnt_d = out_cnt_q + 1'b1;
    if (state_q == FEED && issued_q == nv_q) state_d = DRAIN;
    if (state_q == DRAIN && out_cnt_d == nv_q) state_d = DONE;
    if (state_q == DONE) state_d = IDLE;
    rd_en_d = issue;
    fei_d   = {TRI_LENGTH{rd_en_q}} & mask_q;
    busy_d  = state_d != IDLE;
    done_d  = state_d == DONE;
    err_d   = start && !accept;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      base_q    <= '0;
      nv_q      <= '0;
      mask_q    <= '0;
      act_q     <= '0;
      issued_q  <= '0;
      out_cnt_q <= '0;
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      fei_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      nv_q      <= nv_d;
      mask_q    <= mask_d;
      act_q     <= act_d;
      issued_q  <= issued_d;
      out_cnt_q <= out_cnt_d;
      rd_addr_q <= rd_addr_d;
      rd_en_q   <= rd_en_d;
      fei_q     <= fei_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end
  assign rd_en          = rd_en_q;
  assign rd_addr        = rd_addr_q;
  assign fifo_enable_in = fei_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign start_err      = err_q;
endmodule

// File: tb/tb_tri_fifo_skew_ctrl.sv
// tb_tri_fifo_skew_ctrl: randomized scoreboard bench; a behavioural downward triangular FIFO
// (lane i delays enable_in by TL-i cycles) closes the loop back into the controller.
module tb_tri_fifo_skew_ctrl;
  localparam int TL = 4;
  localparam int AW = 10;
  localparam int CW = 8;
  typedef struct {logic [CW-1:0] n; logic [TL-1:0] m;} tile_t;
  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, hold = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] num_vec = '0;
  logic [TL-1:0] lane_mask = '0, inj = '0;
  logic rd_en, busy, done, start_err;
  logic [AW-1:0] rd_addr;
  logic [TL-1:0] fei, eo;
  logic [TL-1:0] hist [1:TL];
  int cyc = 0, n_cmp = 0, n_fail = 0;
  tile_t tile_q[$];
  logic [AW-1:0] addr_q[$];
  int err_q[$];
  tile_t cur = '{'0, '0};
  bit t_act = 0, exp_rd_prev = 0, hold_prev = 0;
  int t_start = 0, exp_done = -1, reads = 0, outs = 0, act = 0;
  tri_fifo_skew_ctrl #(.TRI_LENGTH(TL), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .num_vec(num_vec),
    .lane_mask(lane_mask), .hold(hold), .rd_en(rd_en), .rd_addr(rd_addr),
    .fifo_enable_in(fei), .fifo_enable_out(eo), .busy(busy), .done(done), .start_err(start_err));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    hist[1] <= fei;
    for (int k = 2; k <= TL; k++) hist[k] <= hist[k-1];
  end
  always_comb begin
    eo = inj;
    for (int i = 0; i < TL; i++) eo[i] = eo[i] | hist[TL-i][i];
  end
  task automatic chk(input string nm, input longint a, input longint e);
    n_cmp++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, a, e);
    end
  endtask
  function automatic int lowest(input logic [TL-1:0] m);
    for (int i = 0; i < TL; i++) if (m[i]) return i;
    return 0;
  endfunction
  // Monitor: reference model derived from the tile-level rules, checked every cycle mid-period.
  always @(negedge clk) begin
    bit exp_rd, exp_dn, exp_err;
    logic [TL-1:0] exp_fei;
    if (!rstn) begin
      t_act = 0; exp_rd_prev = 0; hold_prev = 0;
      tile_q.delete(); addr_q.delete(); err_q.delete();
    end else begin
      if (!t_act && tile_q.size() != 0) begin
        cur = tile_q.pop_front(); t_act = 1; t_start = cyc; reads = 0; outs = 0;
        exp_done = cur.n == 0 ? cyc + 1 : -1; act = lowest(cur.m);
      end
      exp_rd = t_act && cyc > t_start && !hold_prev && reads < int'(cur.n);
      if (exp_rd || rd_en) chk("rd_en", rd_en, exp_rd);
      if (rd_en) begin
        if (addr_q.size() == 0) chk("rd_addr_extra", 1, 0);
        else chk("rd_addr", rd_addr, addr_q.pop_front());
      end
      if (exp_rd) reads++;
      exp_fei = exp_rd_prev ? cur.m : '0;
      if (t_act || fei != '0) chk("fifo_enable_in", fei, exp_fei);
      if (t_act && cyc > t_start && eo[act] && outs < int'(cur.n)) begin
        outs++;
        if (outs == int'(cur.n)) exp_done = cyc + 1;
      end
      chk("busy", busy, t_act && cyc > t_start);
      exp_dn = t_act && cyc == exp_done;
      if (exp_dn || done) chk("done", done, exp_dn);
      if (exp_dn) begin
        chk("reads_issued", reads, cur.n);
        t_act = 0;
      end
      exp_err = err_q.size() != 0 && err_q[0] + 1 == cyc;
      if (exp_err) void'(err_q.pop_front());
      if (exp_err || start_err) chk("start_err", start_err, exp_err);
      exp_rd_prev = exp_rd;
      hold_prev = hold;
    end
  end
  task automatic issue(input logic [AW-1:0] b, input logic [CW-1:0] n, input logic [TL-1:0] m);
    start = 1; base_addr = b; num_vec = n; lane_mask = m;
    if (m == '0) err_q.push_back(cyc);
    else begin
      tile_q.push_back('{n, m});
      for (int i = 0; i < int'(n); i++) addr_q.push_back(b + AW'(i));
    end
  endtask
  task automatic wait_idle(input int s, input int hmode, input bit inj_start);
    int k = 0;
    while ((t_act || tile_q.size() != 0) && k < 3000) begin
      hold = hmode == 1 ? (cyc == s + 2) : hmode == 2 ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (inj_start && t_act && $urandom_range(0, 7) == 0) begin
        start = 1; base_addr = AW'($urandom); num_vec = CW'($urandom); lane_mask = TL'($urandom);
        err_q.push_back(cyc);
      end
      @(posedge clk); #1;
      start = 0; hold = 0; k++;
    end
    if (k >= 3000) chk("tile_timeout", k, 0);
  endtask
  task automatic run_tile(input logic [AW-1:0] b, input logic [CW-1:0] n, input logic [TL-1:0] m,
                          input int hmode, input bit inj_start);
    int s;
    @(posedge clk); #1;
    s = cyc; hold = 0;
    issue(b, n, m);
    @(posedge clk); #1;
    start = 0;
    wait_idle(s, hmode, inj_start);
  endtask
  task automatic gap(input int n);
    repeat (n) begin @(posedge clk); #1; inj = TL'($urandom); end
    @(posedge clk); #1; inj = '0;
  endtask
  initial begin
    int s;
    logic [TL-1:0] m;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {rd_en, rd_addr, fei, busy, done, start_err}, 0);
    rstn = 1;
    gap(4);
    run_tile(AW'('h10), 3, 4'hF, 0, 0);
    run_tile(AW'('h10), 3, 4'hF, 1, 0);
    run_tile(AW'('h40), 2, 4'b1100, 0, 0);
    run_tile(AW'('h50), 0, 4'hF, 0, 0);
    run_tile(AW'('h60), 5, 4'h0, 0, 0);
    gap(2);
    run_tile(AW'('h70), 6, 4'b1010, 0, 1);
    run_tile(AW'('h3FE), 4, 4'hF, 0, 0);
    // num_vec=0 tile, start rejected in its DONE cycle, then accepted in the following IDLE cycle
    @(posedge clk); #1;
    s = cyc; issue(AW'('h5), 0, 4'hF);
    @(posedge clk); #1;
    start = 1; base_addr = AW'('h7); num_vec = 2; lane_mask = 4'hF; err_q.push_back(cyc);
    @(posedge clk); #1;
    issue(AW'('h90), 2, 4'b0100);
    @(posedge clk); #1;
    start = 0;
    wait_idle(s, 0, 0);
    for (int t = 0; t < 8; t++) begin
      gap($urandom_range(1, 4));
      m = TL'($urandom);
      if (m == '0) m = 4'b0010;
      run_tile(AW'($urandom), CW'($urandom_range(1, 12)), m, $urandom_range(0, 2), 1);
    end
    run_tile(AW'('h100), 255, 4'b0110, 2, 0);
    // Reset while draining: abandon tile, outputs clear asynchronously, no done afterwards
    @(posedge clk); #1;
    issue(AW'('h20), 5, 4'hF);
    @(posedge clk); #1;
    start = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("busy_before_reset", busy, 1);
    rstn = 0;
    #1;
    chk("reset_mid_tile", {rd_en, rd_addr, fei, busy, done, start_err}, 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1;
    gap(8);
    run_tile(AW'('h30), 4, 4'b0011, 0, 0);
    gap(3);
    chk("pending_addr", addr_q.size(), 0);
    chk("pending_err", err_q.size(), 0);
    chk("pending_tile", tile_q.size() + int'(t_act), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
